// File: rtl/prog_loader_if.sv
// Byte-stream / ROM-write bundle for the boot program loader.
// Optional LOADER_CHECKSUM_EN adds the 8-bit checksum status signal.
interface prog_loader_if #(parameter int ADDR_W = 9);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_last;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-2:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        checksum;

  modport master (output start, byte_valid, byte_data, byte_last,
                  input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset,
                         busy, done, error, word_count, checksum);
  modport slave  (input  start, byte_valid, byte_data, byte_last,
                  output byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset,
                         busy, done, error, word_count, checksum);
`else
  modport master (output start, byte_valid, byte_data, byte_last,
                  input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset,
                         busy, done, error, word_count);
  modport slave  (input  start, byte_valid, byte_data, byte_last,
                  output byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset,
                         busy, done, error, word_count);
`endif
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: packs a big-endian byte stream into 32-bit words,
// writes them to the instruction ROM and releases cpu_reset once the image is
// complete. Optional LOADER_CHECKSUM_EN adds a mod-256 byte checksum output.
module prog_loader #(
  parameter int ADDR_W = 9
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_word;
  logic [1:0]        r_k;
  logic              r_last;
  logic [ADDR_W-2:0] r_wc;
  logic              w_byte_ready, w_mem_we, w_busy, w_done, w_error, w_cpu_reset;
  logic              w_accept, w_start, w_full;

  assign w_accept = bus.byte_valid && w_byte_ready;
  assign w_start  = bus.start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign w_full   = (r_addr == LAST_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and state-derived outputs (no input-to-output paths)
  always_comb begin
    w_next       = r_state;
    w_byte_ready = 1'b0;
    w_mem_we     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_error      = 1'b0;
    w_cpu_reset  = 1'b1;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_RECV;
      S_RECV: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (bus.byte_valid) begin
          if (r_k == 2'd3)        w_next = S_WRITE;
          else if (bus.byte_last) w_next = S_ERR;
        end
      end
      S_WRITE: begin
        w_mem_we = 1'b1;
        w_busy   = 1'b1;
        if (r_last)      w_next = S_DONE;
        else if (w_full) w_next = S_ERR;
        else             w_next = S_RECV;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_cpu_reset = 1'b0;
        if (bus.start) w_next = S_RECV;
      end
      S_ERR: begin
        w_error = 1'b1;
        if (bus.start) w_next = S_RECV;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Word assembly, address and word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_word <= '0;
      r_k    <= '0;
      r_last <= 1'b0;
      r_wc   <= '0;
    end else begin
      if (w_start) begin
        r_addr <= '0;
        r_k    <= '0;
        r_wc   <= '0;
      end
      if (w_accept) begin
        case (r_k)
          2'd0: r_word[31:24] <= bus.byte_data;
          2'd1: r_word[23:16] <= bus.byte_data;
          2'd2: r_word[15:8]  <= bus.byte_data;
          default: r_word[7:0] <= bus.byte_data;
        endcase
        r_k <= r_k + 2'd1;  // wraps to 0 after the 4th byte
        if (r_k == 2'd3) r_last <= bus.byte_last;
      end
      if (r_state == S_WRITE) begin
        r_wc <= r_wc + (ADDR_W-1)'(1);
        // address only advances when another word can follow
        if (!r_last && !w_full) r_addr <= r_addr + ADDR_W'(4);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;

  // Running mod-256 sum of accepted bytes for the current load
  always_ff @(posedge clk) begin
    if (reset)         r_sum <= '0;
    else if (w_start)  r_sum <= '0;
    else if (w_accept) r_sum <= r_sum + bus.byte_data;
  end

  assign bus.checksum = r_sum;
`endif

  assign bus.byte_ready = w_byte_ready;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_word;
  assign bus.cpu_reset  = w_cpu_reset;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.error      = w_error;
  assign bus.word_count = r_wc;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed image loads plus randomized images checked
// against a byte-list reference model. Two instances: ADDR_W=9 and ADDR_W=4.
module tb_prog_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(9)) abus();
  prog_loader_if #(.ADDR_W(4)) bbus();

  prog_loader #(.ADDR_W(9)) dut_a (.clk(clk), .reset(reset), .bus(abus.slave));
  prog_loader #(.ADDR_W(4)) dut_b (.clk(clk), .reset(reset), .bus(bbus.slave));

  int vectors = 0, miscompares = 0;

  logic [40:0] a_wr[$], b_wr[$], exp_wr[$];
  int          a_ovl = 0;
  logic [7:0]  img[$];
  bit          lst[$];
  bit          exp_done, exp_err;
  int          exp_wc;
  logic [7:0]  exp_sum;

  // capture ROM writes and any overlap of byte_ready with a write cycle
  always @(negedge clk) begin
    if (abus.mem_we) a_wr.push_back({abus.mem_addr, abus.mem_wdata});
    if (abus.mem_we && abus.byte_ready) a_ovl++;
    if (bbus.mem_we) b_wr.push_back({5'd0, bbus.mem_addr, bbus.mem_wdata});
  end

  // reference: walk the byte list, emit words, stop at last/error/full
  task automatic model(input int cap);
    logic [31:0] word = '0;
    int k = 0;
    exp_wr.delete(); exp_done = 0; exp_err = 0; exp_wc = 0; exp_sum = 8'h00;
    for (int i = 0; i < img.size(); i++) begin
      exp_sum = exp_sum + img[i];
      word = word | (32'(img[i]) << (24 - 8*k));
      if (k == 3) begin
        exp_wr.push_back({9'(4*exp_wc), word});
        exp_wc++; word = '0; k = 0;
        if (lst[i]) begin exp_done = 1; break; end
        if (exp_wc == cap) begin exp_err = 1; break; end
      end else begin
        if (lst[i]) begin exp_err = 1; break; end
        k++;
      end
    end
  endtask

  task automatic do_reset();
    abus.start = 0; abus.byte_valid = 0; abus.byte_data = 0; abus.byte_last = 0;
    bbus.start = 0; bbus.byte_valid = 0; bbus.byte_data = 0; bbus.byte_last = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic pulse_start_a();
    abus.start = 1;
    @(negedge clk);
    abus.start = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit l);
    int t = 0;
    abus.byte_valid = 1; abus.byte_data = d; abus.byte_last = l;
    while (!abus.byte_ready && t < 50) begin @(negedge clk); t++; end
    if (!abus.byte_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_byte timeout: byte_ready stayed %b, required 1", abus.byte_ready);
    end else @(negedge clk);
  endtask

  task automatic run_load(input int gap_max);
    a_wr.delete(); a_ovl = 0;
    pulse_start_a();
    for (int i = 0; i < img.size(); i++) begin
      send_byte(img[i], lst[i]);
      if (gap_max > 0) begin
        int g = $urandom_range(gap_max, 0);
        abus.byte_valid = 0;
        repeat (g) @(negedge clk);
      end
    end
    abus.byte_valid = 0; abus.byte_last = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_image8();
    img = '{8'h8C, 8'h10, 8'h00, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00};
    lst = '{0, 0, 0, 0, 0, 0, 0, 1};
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({abus.cpu_reset, abus.byte_ready, abus.mem_we, abus.busy, abus.done, abus.error} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_flags got %b required 100000",
        {abus.cpu_reset, abus.byte_ready, abus.mem_we, abus.busy, abus.done, abus.error});
    end
    vectors++;
    if (abus.mem_addr !== 9'h0 || abus.mem_wdata !== 32'h0 || abus.word_count !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_regs got addr %h data %h wc %0d required 0/0/0",
        abus.mem_addr, abus.mem_wdata, abus.word_count);
    end
`ifdef LOADER_CHECKSUM_EN
    vectors++;
    if (abus.checksum !== 8'h00) begin
      miscompares++; $display("FAIL reset_checksum got %h required 00", abus.checksum);
    end
`endif
  endtask

  task automatic test_image(input int gap_max, input string nm);
    do_reset();
    set_image8();
    run_load(gap_max);
    vectors++;
    if (a_wr.size() != 2) begin
      miscompares++; $display("FAIL %s write_count got %0d required 2", nm, a_wr.size());
    end else begin
      vectors++;
      if (a_wr[0] !== {9'h000, 32'h8C100005}) begin
        miscompares++; $display("FAIL %s write0 got %h required %h", nm, a_wr[0], {9'h000, 32'h8C100005});
      end
      vectors++;
      if (a_wr[1] !== {9'h004, 32'h01000000}) begin
        miscompares++; $display("FAIL %s write1 got %h required %h", nm, a_wr[1], {9'h004, 32'h01000000});
      end
    end
    vectors++;
    if ({abus.done, abus.cpu_reset, abus.error} !== 3'b100 || abus.word_count !== 8'd2) begin
      miscompares++;
      $display("FAIL %s final got done/cpu_reset/error %b wc %0d required 100 wc 2",
        nm, {abus.done, abus.cpu_reset, abus.error}, abus.word_count);
    end
    vectors++;
    if (a_ovl != 0) begin
      miscompares++; $display("FAIL %s ready_in_write got %0d cycles required 0", nm, a_ovl);
    end
  endtask

  task automatic test_back_to_back();
    test_image(0, "back_to_back");
  endtask

  task automatic test_short_last();
    do_reset();
    img = '{8'hAA, 8'hBB, 8'hCC};
    lst = '{0, 0, 1};
    run_load(0);
    vectors++;
    if (a_wr.size() != 0 || {abus.error, abus.cpu_reset, abus.done} !== 3'b110 || abus.word_count !== 8'd0) begin
      miscompares++;
      $display("FAIL short_last got writes %0d err/cpu_reset/done %b wc %0d required 0 110 0",
        a_wr.size(), {abus.error, abus.cpu_reset, abus.done}, abus.word_count);
    end
    pulse_start_a();
    vectors++;
    if ({abus.error, abus.busy, abus.byte_ready} !== 3'b011) begin
      miscompares++;
      $display("FAIL short_restart got err/busy/ready %b required 011", {abus.error, abus.busy, abus.byte_ready});
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    a_wr.delete();
    pulse_start_a();
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b0);
    abus.byte_valid = 0;
    reset = 1;
    @(negedge clk);
    vectors++;
    if ({abus.mem_we, abus.cpu_reset, abus.busy, abus.byte_ready} !== 4'b0100 || abus.word_count !== 8'd0) begin
      miscompares++;
      $display("FAIL midload_reset got we/cpu_reset/busy/ready %b wc %0d required 0100 wc 0",
        {abus.mem_we, abus.cpu_reset, abus.busy, abus.byte_ready}, abus.word_count);
    end
    reset = 0;
    @(negedge clk);
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    lst = '{0, 0, 0, 1};
    run_load(0);
    vectors++;
    if (a_wr.size() != 1 || abus.done !== 1'b1) begin
      miscompares++; $display("FAIL midload_reload got writes %0d done %b required 1 1", a_wr.size(), abus.done);
    end else begin
      vectors++;
      if (a_wr[0] !== {9'h000, 32'h11223344}) begin
        miscompares++; $display("FAIL midload_word got %h required %h", a_wr[0], {9'h000, 32'h11223344});
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    b_wr.delete();
    bbus.start = 1;
    @(negedge clk);
    bbus.start = 0;
    for (int i = 0; i < 16; i++) begin
      int t = 0;
      bbus.byte_valid = 1; bbus.byte_data = 8'(i); bbus.byte_last = 0;
      while (!bbus.byte_ready && t < 50) begin @(negedge clk); t++; end
      if (!bbus.byte_ready) begin
        vectors++; miscompares++;
        $display("FAIL full_send timeout at byte %0d: byte_ready %b required 1", i, bbus.byte_ready);
        break;
      end
      @(negedge clk);
    end
    bbus.byte_valid = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (b_wr.size() != 4) begin
      miscompares++; $display("FAIL full_writes got %0d required 4", b_wr.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        logic [31:0] d = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
        vectors++;
        if (b_wr[w] !== {5'd0, 4'(4*w), d}) begin
          miscompares++; $display("FAIL full_write%0d got %h required %h", w, b_wr[w], {5'd0, 4'(4*w), d});
        end
      end
    end
    vectors++;
    if ({bbus.error, bbus.byte_ready, bbus.done} !== 3'b100 || bbus.word_count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_final got err/ready/done %b wc %0d required 100 wc 4",
        {bbus.error, bbus.byte_ready, bbus.done}, bbus.word_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int nw = $urandom_range(6, 1);
      int nb = 4 * nw;
      if ($urandom_range(3, 0) == 0) nb = 4 * (nw - 1) + $urandom_range(3, 1);
      img.delete(); lst.delete();
      for (int i = 0; i < nb; i++) begin
        img.push_back(8'($urandom));
        lst.push_back(i == nb - 1);
      end
      model(128);
      run_load(2);
      vectors++;
      if (a_wr.size() != exp_wr.size()) begin
        miscompares++; $display("FAIL rand%0d write_count got %0d required %0d", n, a_wr.size(), exp_wr.size());
      end else begin
        for (int w = 0; w < exp_wr.size(); w++) begin
          vectors++;
          if (a_wr[w] !== exp_wr[w]) begin
            miscompares++; $display("FAIL rand%0d write%0d got %h required %h", n, w, a_wr[w], exp_wr[w]);
          end
        end
      end
      vectors++;
      if ({abus.done, abus.error, abus.cpu_reset} !== {exp_done, exp_err, !exp_done} ||
          abus.word_count !== 8'(exp_wc) || a_ovl != 0) begin
        miscompares++;
        $display("FAIL rand%0d status got done/err/cpu_reset %b wc %0d ovl %0d required %b wc %0d ovl 0",
          n, {abus.done, abus.error, abus.cpu_reset}, abus.word_count, a_ovl,
          {exp_done, exp_err, !exp_done}, exp_wc);
      end
`ifdef LOADER_CHECKSUM_EN
      vectors++;
      if (abus.checksum !== exp_sum) begin
        miscompares++; $display("FAIL rand%0d checksum got %h required %h", n, abus.checksum, exp_sum);
      end
`endif
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    set_image8();
    run_load(1);
    vectors++;
    if (abus.checksum !== 8'hA2 || abus.done !== 1'b1) begin
      miscompares++; $display("FAIL checksum_done got %h done %b required A2 1", abus.checksum, abus.done);
    end
    pulse_start_a();
    vectors++;
    if (abus.checksum !== 8'h00) begin
      miscompares++; $display("FAIL checksum_restart got %h required 00", abus.checksum);
    end
  endtask
`endif

  initial begin
    reset = 1;
    test_reset();
    test_image(3, "image_gaps");
    test_back_to_back();
    test_short_last();
    test_reset_midload();
    test_full();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // hard stop so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL global_timeout reached, required completion");
    $fatal(1);
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of the instruction ROM. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes each word into the ROM through a dedicated write port. It holds the pipeline in reset (cpu_reset) until a complete image is loaded, then releases it so fetch starts at PC 0.

Parameters:
ADDR_W, 9, byte-address width of the instruction ROM; capacity 2^ADDR_W bytes = 2^(ADDR_W-2) words

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  pulse: begin a new load at address 0
byte_valid  input  1  byte_data holds a valid byte
byte_data  input  8  stream byte; first byte of each word is MSB [31:24]
byte_last  input  1  qualifies the final byte of the image; sampled with byte_valid
byte_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  ROM write strobe, one cycle per word
mem_addr  output  ADDR_W  word-aligned byte address, bits [1:0] always 0
mem_wdata  output  32  assembled instruction word
cpu_reset  output  1  holds the pipeline in reset; low only in DONE
busy  output  1  high in RECV or WRITE
done  output  1  high in DONE
error  output  1  high in ERR
word_count  output  ADDR_W-1  number of words written in the current load

Behaviour:
- Interface: clk is the clock. reset is synchronous and active-high.
- Reset values (all outputs): state IDLE, cpu_reset=1, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, word_count=0, byte index k=0.
- Reset asserted mid-load: the block returns to IDLE on that edge. mem_we is low from that edge on. Partial words are discarded.
- Transfer rule: a byte is accepted only on an edge where byte_valid=1 and byte_ready=1. byte_valid while byte_ready=0 is ignored, and the source must hold the byte.
- IDLE:
  - byte_ready=0, cpu_reset=1.
  - start=1 -> RECV; clears mem_addr, k, word_count, error.
- RECV:
  - byte_ready=1.
  - Accepted byte goes to word bits [31-8k -: 8], then k increments.
  - Accept with k=3 -> WRITE; k returns to 0 and the byte_last value of that byte is latched.
  - Accept with byte_last=1 and k<3 -> ERR; the partial word is not written.
- WRITE:
  - Lasts exactly 1 cycle. byte_ready=0, mem_we=1, mem_wdata = assembled word, mem_addr = current address.
  - Latency: the 4th byte is accepted at edge N, and mem_we is high during the cycle between edge N and edge N+1.
  - At the exit edge word_count increments, then the first matching rule applies:
    - latched last=1 -> DONE
    - mem_addr = 2^ADDR_W-4 (ROM full, no last) -> ERR
    - otherwise mem_addr += 4 -> RECV
- DONE:
  - done=1, cpu_reset=0; the pipeline runs.
  - start=1 -> RECV with cpu_reset=1 again on that edge; load state is cleared as in IDLE.
- ERR:
  - error=1, cpu_reset=1, byte_ready=0.
  - start=1 -> RECV, clearing error.
- start while in RECV or WRITE is ignored.
- word_count saturates by construction, since ERR or DONE is reached at full capacity.
- All outputs are registered or derived from state only; there are no combinational paths from inputs to byte_ready or mem_we.

Optional Feature:
LOADER_CHECKSUM_EN:
- Defined: adds output port checksum (8 bits) = modulo-256 sum of all accepted bytes in the current load. Cleared on reset and on the accepting start edge. Updated on each accept edge. Holds its value in DONE and ERR.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- start, then 8 bytes 8C 10 00 05 01 00 00 00 with byte_last on the 8th, continuous valid -> mem_we pulses twice: (addr 0x000, 0x8C100005), then (0x004, 0x01000000). Final state done=1, cpu_reset=0, word_count=2, error=0.
- Same image with byte_valid held high continuously across the WRITE cycles -> no byte lost or duplicated: exactly 8 accepts, same two writes, byte_ready low during each WRITE cycle.
- start, bytes AA BB CC with byte_last on CC -> no mem_we, error=1, cpu_reset=1, word_count=0. A following start re-enters RECV with error=0.
- ADDR_W=4, start, 16 bytes 00..0F with no byte_last -> 4 writes at addrs 0,4,8,C (last data 0x0C0D0E0F), then error=1, word_count=4, byte_ready=0.
- Reset asserted after 5 accepted bytes -> next cycle IDLE: mem_we=0, word_count=0, cpu_reset=1. A subsequent start plus 4 bytes 11 22 33 44 with last -> write (0x000, 0x11223344), then done=1.
- With LOADER_CHECKSUM_EN defined: load 8C 10 00 05 01 00 00 00 -> checksum=0xA2 in DONE. On the next start, checksum=0x00.
